// File: rtl/riscv_writeback_pipe.sv
// ---------------------------------------------------------------------------
// riscv_writeback_pipe
//
// Elastic writeback stage. Carries the retire payload (rd write, CSR write,
// exception, instruction-count flag) from the memory stage to the
// register-file / CSR write ports through DEPTH ready/valid register slices.
// Slice 0 takes the input, slice DEPTH-1 drives the outputs.
//
// Ports
//   clk, reset_n              clock (rising edge), async active-low reset
//   flush                     drop every in-flight entry and this cycle's input
//   in_valid / in_ready       upstream handshake
//   *_in                      retire payload from the memory stage
//   out_valid / out_ready     downstream handshake on the head slice
//   *_out                     head payload; write-enables are gated by out_valid,
//                             rd writes to x0 are suppressed
//   instret                   64-bit retired-instruction counter (wraps)
//   fwd_addr/fwd_hit/fwd_data forwarding lookup for decode hazard logic,
//                             present only when RISCV_WB_FWD_EN is defined
//
// Configuration macro: RISCV_WB_FWD_EN (undefined by default, no forwarding).
// DEPTH is legal from 1 to 4.
// ---------------------------------------------------------------------------
module riscv_writeback_pipe #(
    parameter int XLEN   = 32,
    parameter int RF_AW  = 5,
    parameter int CSR_AW = 12,
    parameter int EXC_W  = 40,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              count_instruction_in,
    input  logic              exception_in,
    input  logic [EXC_W-1:0]  exception_context_in,
    input  logic [CSR_AW-1:0] csr_addr_in,
    input  logic [1:0]        csr_write_in,
    input  logic [XLEN-1:0]   csr_data_in,
    input  logic              rd_write_in,
    input  logic [RF_AW-1:0]  rd_addr_in,
    input  logic [XLEN-1:0]   rd_data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              count_instruction_out,
    output logic              exception_out,
    output logic [EXC_W-1:0]  exception_context_out,
    output logic [CSR_AW-1:0] csr_addr_out,
    output logic [1:0]        csr_write_out,
    output logic [XLEN-1:0]   csr_data_out,
    output logic              rd_write_out,
    output logic [RF_AW-1:0]  rd_addr_out,
    output logic [XLEN-1:0]   rd_data_out,
    output logic [63:0]       instret
`ifdef RISCV_WB_FWD_EN
    ,
    input  logic [RF_AW-1:0]  fwd_addr,
    output logic              fwd_hit,
    output logic [XLEN-1:0]   fwd_data
`endif
);

    typedef struct packed {
        logic              count;
        logic              exception;
        logic [EXC_W-1:0]  exc_ctx;
        logic [CSR_AW-1:0] csr_addr;
        logic [1:0]        csr_write;
        logic [XLEN-1:0]   csr_data;
        logic              rd_write;
        logic [RF_AW-1:0]  rd_addr;
        logic [XLEN-1:0]   rd_data;
    } payload_t;

    localparam int       PAYLOAD_W    = $bits(payload_t);
    localparam payload_t PAYLOAD_ZERO = payload_t'({PAYLOAD_W{1'b0}});

    logic [DEPTH-1:0] valid_r;
    payload_t         slice_r [DEPTH];
    payload_t         src_s   [DEPTH];
    logic [DEPTH-1:0] src_valid_s;
    logic [DEPTH-1:0] move_s;
    logic [DEPTH-1:0] load_s;
    payload_t         in_payload_s;
    payload_t         head_s;
    logic             head_fire_s;
    logic [63:0]      instret_r;

    // Gather the upstream payload into one struct
    always_comb begin
        in_payload_s           = PAYLOAD_ZERO;
        in_payload_s.count     = count_instruction_in;
        in_payload_s.exception = exception_in;
        in_payload_s.exc_ctx   = exception_context_in;
        in_payload_s.csr_addr  = csr_addr_in;
        in_payload_s.csr_write = csr_write_in;
        in_payload_s.csr_data  = csr_data_in;
        in_payload_s.rd_write  = rd_write_in;
        in_payload_s.rd_addr   = rd_addr_in;
        in_payload_s.rd_data   = rd_data_in;
    end

    // Each slice is fed by the input (slice 0) or by the slice before it
    always_comb begin
        src_valid_s    = {DEPTH{1'b0}};
        src_s[0]       = in_payload_s;
        src_valid_s[0] = in_valid;
        for (int k = 1; k < DEPTH; k++) begin
            src_s[k]       = slice_r[k-1];
            src_valid_s[k] = valid_r[k-1];
        end
    end

    // Ready chain walked from the head back to the input, so a slice whose
    // contents leave this cycle can refill in the same cycle (no bubble)
    always_comb begin
        move_s          = {DEPTH{1'b0}};
        load_s          = {DEPTH{1'b0}};
        move_s[DEPTH-1] = valid_r[DEPTH-1] & out_ready;
        load_s[DEPTH-1] = ~valid_r[DEPTH-1] | move_s[DEPTH-1];
        for (int k = DEPTH - 2; k >= 0; k--) begin
            move_s[k] = valid_r[k] & load_s[k+1];
            load_s[k] = ~valid_r[k] | move_s[k];
        end
    end

    assign in_ready    = load_s[0];
    assign head_s      = slice_r[DEPTH-1];
    assign head_fire_s = valid_r[DEPTH-1] & out_ready;

    // Valid bits: flush empties every slice and drops this cycle's input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= {DEPTH{1'b0}};
        end else if (flush) begin
            valid_r <= {DEPTH{1'b0}};
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (load_s[k]) begin
                    valid_r[k] <= src_valid_s[k];
                end
            end
        end
    end

    // Payload registers: only real entries are captured, and a flush leaves
    // the stored payload untouched
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                slice_r[k] <= PAYLOAD_ZERO;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (!flush && load_s[k] && src_valid_s[k]) begin
                    slice_r[k] <= src_s[k];
                end
            end
        end
    end

    // Retired-instruction counter; a head handshake in a flush cycle counts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instret_r <= 64'd0;
        end else if (head_fire_s && head_s.count && !head_s.exception) begin
            instret_r <= instret_r + 64'd1;
        end
    end

    assign instret               = instret_r;
    assign out_valid             = valid_r[DEPTH-1];
    assign count_instruction_out = head_s.count & valid_r[DEPTH-1];
    assign exception_out         = head_s.exception & valid_r[DEPTH-1];
    assign exception_context_out = head_s.exc_ctx;
    assign csr_addr_out          = head_s.csr_addr;
    assign csr_write_out         = valid_r[DEPTH-1] ? head_s.csr_write : 2'b00;
    assign csr_data_out          = head_s.csr_data;
    // x0 is hard-wired zero, so a write to it is never issued
    assign rd_write_out          = head_s.rd_write & valid_r[DEPTH-1] &
                                   (head_s.rd_addr != {RF_AW{1'b0}});
    assign rd_addr_out           = head_s.rd_addr;
    assign rd_data_out           = head_s.rd_data;

`ifdef RISCV_WB_FWD_EN
    logic            fwd_hit_s;
    logic [XLEN-1:0] fwd_data_s;

    // Scan oldest to youngest so the youngest matching slice wins
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = {XLEN{1'b0}};
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (valid_r[k] && slice_r[k].rd_write &&
                (slice_r[k].rd_addr == fwd_addr) &&
                (fwd_addr != {RF_AW{1'b0}})) begin
                fwd_hit_s  = 1'b1;
                fwd_data_s = slice_r[k].rd_data;
            end else begin
                fwd_hit_s  = fwd_hit_s;
                fwd_data_s = fwd_data_s;
            end
        end
    end

    assign fwd_hit  = fwd_hit_s;
    assign fwd_data = fwd_data_s;
`endif

    riscv_writeback_pipe_checker #(
        .XLEN  (XLEN),
        .RF_AW (RF_AW)
    ) u_checker (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .rd_write_out (rd_write_out),
        .rd_addr_out  (rd_addr_out),
        .rd_data_out  (rd_data_out),
        .full         (&valid_r)
    );

endmodule

// ---------------------------------------------------------------------------
// riscv_writeback_pipe_checker
//
// Protocol properties of the writeback pipe: no x0 write, head held stable
// under backpressure, and no acceptance when every slice is occupied and the
// head is stalled.
// ---------------------------------------------------------------------------
module riscv_writeback_pipe_checker #(
    parameter int XLEN  = 32,
    parameter int RF_AW = 5
) (
    input logic             clk,
    input logic             reset_n,
    input logic             flush,
    input logic             in_ready,
    input logic             out_valid,
    input logic             out_ready,
    input logic             rd_write_out,
    input logic [RF_AW-1:0] rd_addr_out,
    input logic [XLEN-1:0]  rd_data_out,
    input logic             full
);

    a_no_x0_write : assert property (@(posedge clk) disable iff (!reset_n)
        rd_write_out |-> (rd_addr_out != {RF_AW{1'b0}}));

    a_head_hold : assert property (@(posedge clk) disable iff (!reset_n)
        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(rd_data_out)));

    a_full_stall : assert property (@(posedge clk) disable iff (!reset_n)
        (full && !out_ready) |-> !in_ready);

endmodule

// File: tb/tb_riscv_writeback_pipe.sv
module tb_riscv_writeback_pipe;

    localparam int DEPTH = 3;

    typedef struct packed {
        logic        count;
        logic        exc;
        logic [39:0] ctx;
        logic [11:0] csr_addr;
        logic [1:0]  csr_w;
        logic [31:0] csr_data;
        logic        rd_w;
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
    } pl_t;

    typedef struct {
        pl_t p;
        int  pos;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    pl_t         drv = '0;
    logic        in_ready, out_valid;
    logic        count_instruction_out, exception_out, rd_write_out;
    logic [39:0] exception_context_out;
    logic [11:0] csr_addr_out;
    logic [1:0]  csr_write_out;
    logic [31:0] csr_data_out, rd_data_out;
    logic [4:0]  rd_addr_out;
    logic [63:0] instret;
`ifdef RISCV_WB_FWD_EN
    logic [4:0]  fwd_addr = 5'd0;
    logic        fwd_hit;
    logic [31:0] fwd_data;
`endif

    ent_t        q[$];
    logic [63:0] m_instret = 64'd0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          last_acc;

    always #5 clk = ~clk;

    riscv_writeback_pipe #(
        .XLEN(32), .RF_AW(5), .CSR_AW(12), .EXC_W(40), .DEPTH(DEPTH)
    ) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .flush                 (flush),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .count_instruction_in  (drv.count),
        .exception_in          (drv.exc),
        .exception_context_in  (drv.ctx),
        .csr_addr_in           (drv.csr_addr),
        .csr_write_in          (drv.csr_w),
        .csr_data_in           (drv.csr_data),
        .rd_write_in           (drv.rd_w),
        .rd_addr_in            (drv.rd_addr),
        .rd_data_in            (drv.rd_data),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .count_instruction_out (count_instruction_out),
        .exception_out         (exception_out),
        .exception_context_out (exception_context_out),
        .csr_addr_out          (csr_addr_out),
        .csr_write_out         (csr_write_out),
        .csr_data_out          (csr_data_out),
        .rd_write_out          (rd_write_out),
        .rd_addr_out           (rd_addr_out),
        .rd_data_out           (rd_data_out),
        .instret               (instret)
`ifdef RISCV_WB_FWD_EN
        ,
        .fwd_addr              (fwd_addr),
        .fwd_hit               (fwd_hit),
        .fwd_data              (fwd_data)
`endif
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic pl_t rand_pl(int max_rd);
        pl_t p;
        p.count    = 1'($urandom_range(0, 1));
        p.exc      = ($urandom_range(0, 7) == 0);
        p.ctx      = {8'($urandom()), $urandom()};
        p.csr_addr = 12'($urandom());
        p.csr_w    = 2'($urandom());
        p.csr_data = $urandom();
        p.rd_w     = 1'($urandom_range(0, 1));
        p.rd_addr  = 5'($urandom_range(0, max_rd));
        p.rd_data  = $urandom();
        return p;
    endfunction

    // Model: queue of entries in arrival order, each with its slice position.
    // An entry advances when the next slot is free or its occupant moves on.
    function automatic bit model_eval(output logic [DEPTH-1:0] mv);
        int n;
        n  = q.size();
        mv = '0;
        for (int i = 0; i < n; i++) begin
            if (q[i].pos == DEPTH - 1)
                mv[i] = out_ready;
            else if (i > 0 && q[i-1].pos == q[i].pos + 1)
                mv[i] = mv[i-1];
            else
                mv[i] = 1'b1;
        end
        return (n == 0) || (q[n-1].pos != 0) || mv[n-1];
    endfunction

    // One clock cycle: evaluate model from current inputs, commit at the edge
    task automatic tick();
        logic [DEPTH-1:0] mv;
        bit               ir, leave;
        int               n;
        ent_t             e;
        @(negedge clk);
        #1;
        ir    = model_eval(mv);
        n     = q.size();
        leave = (n > 0) && (q[0].pos == DEPTH - 1) && out_ready;
        last_acc = in_valid && ir && !flush && reset_n;
        @(posedge clk);
        if (reset_n) begin
            if (leave && q[0].p.count && !q[0].p.exc) m_instret = m_instret + 64'd1;
            if (flush) begin
                q.delete();
            end else begin
                for (int i = 0; i < n; i++)
                    if (mv[i]) q[i].pos = q[i].pos + 1;
                if (leave) void'(q.pop_front());
                if (in_valid && ir) begin
                    e.p = drv;
                    e.pos = 0;
                    q.push_back(e);
                end
            end
        end
        #1;
    endtask

    // Compare process: every cycle, DUT outputs against the model
    always @(negedge clk) begin
        logic [DEPTH-1:0] mv;
        bit               ir, ov;
        pl_t              h;
        ir = model_eval(mv);
        ov = (q.size() > 0) && (q[0].pos == DEPTH - 1);
        chk("out_valid", out_valid, ov);
        chk("in_ready", in_ready, ir);
        chk("instret", instret, m_instret);
        if (ov) begin
            h = q[0].p;
            chk("rd_data_out", rd_data_out, h.rd_data);
            chk("rd_addr_out", rd_addr_out, h.rd_addr);
            chk("rd_write_out", rd_write_out, h.rd_w && (h.rd_addr != 5'd0));
            chk("csr_addr_out", csr_addr_out, h.csr_addr);
            chk("csr_data_out", csr_data_out, h.csr_data);
            chk("csr_write_out", csr_write_out, h.csr_w);
            chk("exc_ctx_out", exception_context_out, h.ctx);
            chk("exception_out", exception_out, h.exc);
            chk("count_out", count_instruction_out, h.count);
        end else begin
            chk("rd_write_out_idle", rd_write_out, 64'd0);
            chk("csr_write_out_idle", csr_write_out, 64'd0);
            chk("exception_out_idle", exception_out, 64'd0);
            chk("count_out_idle", count_instruction_out, 64'd0);
        end
`ifdef RISCV_WB_FWD_EN
        begin
            bit          hit;
            logic [31:0] d;
            hit = 1'b0;
            d   = 32'd0;
            foreach (q[i])
                if (q[i].p.rd_w && q[i].p.rd_addr == fwd_addr && fwd_addr != 5'd0) begin
                    hit = 1'b1;
                    d   = q[i].p.rd_data;
                end
            chk("fwd_hit", fwd_hit, hit);
            chk("fwd_data", fwd_data, d);
        end
`endif
    end

    initial begin
        pl_t first;
        int  acc;

        // Reset
        tick();
        tick();
        chk("reset_out_valid", out_valid, 64'd0);
        chk("reset_instret", instret, 64'd0);
        chk("reset_in_ready", in_ready, 64'd1);
        reset_n = 1'b1;
        tick();

        // Streaming: 8 back-to-back counted entries, latency DEPTH-1 edges
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drv       = rand_pl(31);
            drv.count = 1'b1;
            drv.exc   = 1'b0;
            in_valid  = 1'b1;
            if (i == 0) first = drv;
            chk("stream_in_ready", in_ready, 64'd1);
            tick();
            if (i < 2) chk("stream_latency_empty", out_valid, 64'd0);
            if (i == 2) begin
                chk("stream_latency_valid", out_valid, 64'd1);
                chk("stream_first_data", rd_data_out, first.rd_data);
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) tick();
        chk("stream_instret", instret, 64'd8);

        // Backpressure: capacity is DEPTH, head held stable
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            drv       = rand_pl(31);
            drv.count = 1'b1;
            drv.exc   = 1'b0;
            in_valid  = 1'b1;
            tick();
            if (last_acc && acc == 0) first = drv;
            if (last_acc) acc++;
        end
        chk("bp_accepted", acc, 64'd3);
        chk("bp_in_ready", in_ready, 64'd0);
        chk("bp_head_valid", out_valid, 64'd1);
        chk("bp_head_rd_data", rd_data_out, first.rd_data);
        chk("bp_head_csr_data", csr_data_out, first.csr_data);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("bp_instret", instret, 64'd11);
        chk("bp_drained", out_valid, 64'd0);

        // x0 suppression and exception
        drv = rand_pl(31);
        drv.rd_addr = 5'd0; drv.rd_w = 1'b1; drv.count = 1'b1; drv.exc = 1'b0;
        in_valid = 1'b1;
        tick();
        drv = rand_pl(31);
        drv.rd_addr = 5'd7; drv.rd_w = 1'b1; drv.count = 1'b1; drv.exc = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("x0_head_valid", out_valid, 64'd1);
        chk("x0_rd_write_out", rd_write_out, 64'd0);
        tick();
        chk("exc_exception_out", exception_out, 64'd1);
        chk("exc_rd_write_out", rd_write_out, 64'd1);
        for (int i = 0; i < 3; i++) tick();
        chk("exc_instret", instret, 64'd12);

        // Flush with a head handshake and an input in the same cycle
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drv = rand_pl(31);
            drv.count = 1'b1; drv.exc = 1'b0;
            in_valid = 1'b1;
            tick();
        end
        out_ready = 1'b1;
        flush = 1'b1;
        drv = rand_pl(31);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 64'd0);
        chk("flush_instret", instret, 64'd13);
        for (int i = 0; i < DEPTH + 1; i++) tick();
        chk("flush_dropped", out_valid, 64'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            drv       = rand_pl(7);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = (c % 200 < 150) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 63) == 0);
`ifdef RISCV_WB_FWD_EN
            fwd_addr  = 5'($urandom_range(0, 7));
`endif
            tick();
        end
        flush = 1'b0;

        // Reset mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drv       = rand_pl(31);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        q.delete();
        m_instret = 64'd0;
        chk("rst_out_valid", out_valid, 64'd0);
        chk("rst_instret", instret, 64'd0);
        chk("rst_rd_data", rd_data_out, 64'd0);
        chk("rst_rd_addr", rd_addr_out, 64'd0);
        chk("rst_csr_data", csr_data_out, 64'd0);
        chk("rst_csr_addr", csr_addr_out, 64'd0);
        chk("rst_exc_ctx", exception_context_out, 64'd0);
        chk("rst_rd_write", rd_write_out, 64'd0);
        tick();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        drv       = rand_pl(31);
        first     = drv;
        tick();
        in_valid = 1'b0;
        chk("rst_lat0", out_valid, 64'd0);
        tick();
        chk("rst_lat1", out_valid, 64'd0);
        tick();
        chk("rst_lat2", out_valid, 64'd1);
        chk("rst_first_data", rd_data_out, first.rd_data);
        for (int i = 0; i < DEPTH + 1; i++) tick();

`ifdef RISCV_WB_FWD_EN
        // Forwarding: youngest x5 wins, x0 never hits
        out_ready = 1'b0;
        drv = rand_pl(31);
        drv.rd_addr = 5'd5; drv.rd_w = 1'b1; drv.rd_data = 32'hA;
        in_valid = 1'b1;
        tick();
        drv.rd_data = 32'hB;
        tick();
        in_valid = 1'b0;
        fwd_addr = 5'd5;
        #1;
        chk("fwd_x5_hit", fwd_hit, 64'd1);
        chk("fwd_x5_data", fwd_data, 64'hB);
        fwd_addr = 5'd0;
        #1;
        chk("fwd_x0_hit", fwd_hit, 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
